// File: rtl/sync_fifo_gen_if.sv
// Producer/consumer handshake bundle for sync_fifo_gen.
// The FIFO sits on the slave modport; the user logic sits on the master modport.
interface sync_fifo_gen_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  flush;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output flush, data_in, wr_en, rd_en,
    input  data_out, data_valid, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  flush, data_in, wr_en, rd_en,
    output data_out, data_valid, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_gen.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy count, synchronous flush and a registered read port.
module sync_fifo_gen #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_gen_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeC    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LastC  = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  data_valid_q, wr_ack_q, overflow_q, underflow_q;
  logic                  full, empty, wr_accept, rd_accept;

  // Flags depend only on the registered count, so there is no input-to-flag path.
  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);

  // Flush masks both requests so nothing is stored or popped in that cycle.
  assign wr_accept = bus.wr_en & ~full  & ~bus.flush;
  assign rd_accept = bus.rd_en & ~empty & ~bus.flush;

  always_comb begin
    count_d = count_q;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ack_q     <= wr_accept;
      overflow_q   <= bus.wr_en & full;
      underflow_q  <= bus.rd_en & empty;
      data_valid_q <= rd_accept;
      count_q      <= count_d;
      if (wr_accept) wr_ptr_q <= (wr_ptr_q == LastC) ? '0 : wr_ptr_q + PW'(1);
      if (rd_accept) begin
        rd_ptr_q   <= (rd_ptr_q == LastC) ? '0 : rd_ptr_q + PW'(1);
        data_out_q <= mem[rd_ptr_q];
      end
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= AfC) && (count_q < DepthC);
  assign bus.almostempty = (count_q <= AeC) && (count_q != '0);
  assign bus.count       = count_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_sync_fifo_gen.sv
// Directed self-checking bench: an 8-deep default FIFO and a 5-deep FIFO with
// custom thresholds, exercised with hand-computed expected values.
module tb_sync_fifo_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  sync_fifo_gen_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) a_if ();
  sync_fifo_gen_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) b_if ();

  sync_fifo_gen #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  sync_fifo_gen #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic wr, input logic rd, input logic [15:0] din);
    a_if.wr_en   = wr;
    a_if.rd_en   = rd;
    a_if.data_in = din;
  endtask

  task automatic drive_b(input logic wr, input logic rd, input logic [15:0] din);
    b_if.wr_en   = wr;
    b_if.rd_en   = rd;
    b_if.data_in = din;
  endtask

  initial begin
    int c;
    drive_a(1'b0, 1'b0, 16'h0);
    drive_b(1'b0, 1'b0, 16'h0);
    a_if.flush = 1'b0;
    b_if.flush = 1'b0;

    // Reset state
    #2;
    chk("rst_count", a_if.count, 0);
    chk("rst_empty", a_if.empty, 1);
    chk("rst_full", a_if.full, 0);
    chk("rst_dout", a_if.data_out, 0);
    tick();
    rst = 1'b0;

    // Three writes and one read, then reset mid-burst
    for (int i = 1; i <= 3; i++) begin
      drive_a(1'b1, 1'b0, 16'h00A0 + 16'(i));
      tick();
    end
    drive_a(1'b0, 1'b1, 16'h0);
    tick();
    chk("pre_rst_dout", a_if.data_out, 16'h00A1);
    chk("pre_rst_count", a_if.count, 2);
    drive_a(1'b1, 1'b0, 16'h00A4);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_count", a_if.count, 0);
    chk("mid_rst_empty", a_if.empty, 1);
    chk("mid_rst_dout", a_if.data_out, 0);
    chk("mid_rst_valid", a_if.data_valid, 0);
    chk("mid_rst_ack", a_if.wr_ack, 0);
    tick();
    chk("in_rst_count", a_if.count, 0);
    chk("in_rst_ack", a_if.wr_ack, 0);
    rst = 1'b0;
    drive_a(1'b1, 1'b0, 16'h00B0);
    tick();
    chk("post_rst_count", a_if.count, 1);
    chk("post_rst_ack", a_if.wr_ack, 1);
    drive_a(1'b0, 1'b1, 16'h0);
    tick();
    chk("post_rst_dout", a_if.data_out, 16'h00B0);
    chk("post_rst_empty", a_if.empty, 1);

    // Fill 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, 1'b0, 16'(i));
      tick();
      chk("fill_ack", a_if.wr_ack, 1);
      chk("fill_count", a_if.count, 32'(i));
      chk("fill_af", a_if.almostfull, (i == 7) ? 32'd1 : 32'd0);
      chk("fill_full", a_if.full, (i == 8) ? 32'd1 : 32'd0);
    end
    drive_a(1'b1, 1'b0, 16'h0009);
    tick();
    chk("ovf_flag", a_if.overflow, 1);
    chk("ovf_ack", a_if.wr_ack, 0);
    chk("ovf_count", a_if.count, 8);
    drive_a(1'b0, 1'b0, 16'h0);
    tick();
    chk("ovf_pulse", a_if.overflow, 0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b0, 1'b1, 16'h0);
      tick();
      chk("drain_dout", a_if.data_out, 32'(i));
      chk("drain_valid", a_if.data_valid, 1);
      chk("drain_count", a_if.count, 32'(8 - i));
      chk("drain_ae", a_if.almostempty, (i == 7) ? 32'd1 : 32'd0);
      chk("drain_empty", a_if.empty, (i == 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk("udf_flag", a_if.underflow, 1);
    chk("udf_valid", a_if.data_valid, 0);
    chk("udf_dout", a_if.data_out, 16'h0008);
    drive_a(1'b0, 1'b0, 16'h0);
    tick();
    chk("udf_pulse", a_if.underflow, 0);

    // Simultaneous read/write at full
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 1'b0, 16'h0010 + 16'(i));
      tick();
    end
    drive_a(1'b1, 1'b1, 16'h0099);
    tick();
    chk("sim_full_count", a_if.count, 7);
    chk("sim_full_ovf", a_if.overflow, 1);
    chk("sim_full_valid", a_if.data_valid, 1);
    chk("sim_full_dout", a_if.data_out, 16'h0010);
    for (int i = 1; i <= 7; i++) begin
      drive_a(1'b0, 1'b1, 16'h0);
      tick();
      chk("sim_drain_dout", a_if.data_out, 32'h10 + 32'(i));
    end

    // Simultaneous at empty: write lands, read is rejected, no write-through
    drive_a(1'b1, 1'b1, 16'h0020);
    tick();
    chk("sim_empty_count", a_if.count, 1);
    chk("sim_empty_udf", a_if.underflow, 1);
    chk("sim_empty_ack", a_if.wr_ack, 1);
    chk("sim_empty_valid", a_if.data_valid, 0);
    chk("sim_empty_dout", a_if.data_out, 16'h0017);
    for (int i = 1; i <= 3; i++) begin
      drive_a(1'b1, 1'b0, 16'h0020 + 16'(i));
      tick();
    end
    drive_a(1'b1, 1'b1, 16'h0024);
    tick();
    chk("sim_mid_count", a_if.count, 4);
    chk("sim_mid_ack", a_if.wr_ack, 1);
    chk("sim_mid_valid", a_if.data_valid, 1);
    chk("sim_mid_dout", a_if.data_out, 16'h0020);

    // Flush at count 5 with a write pending
    drive_a(1'b1, 1'b0, 16'h0025);
    tick();
    chk("pre_flush_count", a_if.count, 5);
    drive_a(1'b1, 1'b0, 16'h0077);
    a_if.flush = 1'b1;
    tick();
    a_if.flush = 1'b0;
    chk("flush_count", a_if.count, 0);
    chk("flush_empty", a_if.empty, 1);
    chk("flush_ack", a_if.wr_ack, 0);
    chk("flush_dout", a_if.data_out, 16'h0020);
    drive_a(1'b1, 1'b0, 16'h0055);
    tick();
    chk("post_flush_count", a_if.count, 1);
    drive_a(1'b0, 1'b1, 16'h0);
    tick();
    chk("post_flush_dout", a_if.data_out, 16'h0055);
    chk("post_flush_valid", a_if.data_valid, 1);
    chk("post_flush_empty", a_if.empty, 1);
    drive_a(1'b0, 1'b0, 16'h0);

    // Depth 5, AF=3, AE=2: 12 writes crossing the pointer wrap
    for (int i = 1; i <= 4; i++) begin
      drive_b(1'b1, 1'b0, 16'(i));
      tick();
      chk("b_fill_count", b_if.count, 32'(i));
      chk("b_fill_af", b_if.almostfull, (i >= 3) ? 32'd1 : 32'd0);
      chk("b_fill_ae", b_if.almostempty, (i <= 2) ? 32'd1 : 32'd0);
    end
    for (int j = 5; j <= 12; j++) begin
      drive_b(1'b1, 1'b1, 16'(j));
      tick();
      chk("b_wrap_dout", b_if.data_out, 32'(j - 4));
      chk("b_wrap_count", b_if.count, 4);
      chk("b_wrap_af", b_if.almostfull, 1);
      chk("b_wrap_full", b_if.full, 0);
    end
    c = 4;
    for (int j = 9; j <= 12; j++) begin
      drive_b(1'b0, 1'b1, 16'h0);
      tick();
      c--;
      chk("b_tail_dout", b_if.data_out, 32'(j));
      chk("b_tail_count", b_if.count, 32'(c));
      chk("b_tail_af", b_if.almostfull, (c >= 3) ? 32'd1 : 32'd0);
      chk("b_tail_ae", b_if.almostempty, (c >= 1 && c <= 2) ? 32'd1 : 32'd0);
    end
    chk("b_end_empty", b_if.empty, 1);
    drive_b(1'b0, 1'b0, 16'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
